// File: rtl/issue_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard_if
// Description : Decode-to-scoreboard handshake. Decode presents an
//               instruction's operand/destination fields and a flush
//               qualifier. The scoreboard answers with stall/issue.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_scoreboard_if #(
    parameter int WAIT_W = 5
);
    logic              id_valid;
    logic [5:0]        id_rs;
    logic [5:0]        id_rt;
    logic              id_use_s;
    logic              id_use_t;
    logic [1:0]        id_rw;
    logic [4:0]        id_rd;
    logic [WAIT_W-1:0] id_wait;
    logic              flush;
    logic              stall;
    logic              issue;

    // Decode side: drives the instruction, observes the hold/accept answer
    modport master (
        output id_valid, id_rs, id_rt, id_use_s, id_use_t,
        output id_rw, id_rd, id_wait, flush,
        input  stall, issue
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_s, id_use_t,
        input  id_rw, id_rd, id_wait, flush,
        output stall, issue
    );
endinterface
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : Register scoreboard and issue controller between decode and
//               execute. Tracks pending writes to 32 GPRs and 32 FPRs with
//               per-register countdowns, and stalls decode on RAW, WAW and
//               long-latency unit (div/inv/sqrt) contention.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int                WAIT_W    = 5,
    parameter logic [WAIT_W-1:0] LONG_CODE = '1
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    issue_scoreboard_if.slave   dec,
    input  wire logic           long_done,
    output logic                long_busy,
    output logic [31:0]         busy_gpr,
    output logic [31:0]         busy_fpr
);

    localparam logic [WAIT_W-1:0] c_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] c_ZERO = '0;

    // Register index = {file, index}; file 1 selects the FPR bank.
    // Entry 0 (GPR 0) is hard-wired to "never pending" and has no storage.
    logic [WAIT_W-1:0] r_cnt [1:63];
    logic [63:1]       r_lf;
    logic              r_long_busy;
    logic [5:0]        r_long_dst;
    logic              r_long_wr;

    logic [63:0]       w_pending;
    logic [5:0]        w_dst;
    logic              w_has_write;
    logic              w_is_long;
    logic              w_raw_s;
    logic              w_raw_t;
    logic              w_waw;
    logic              w_long_conflict;
    logic              w_stall;
    logic              w_issue;
    logic              w_set;
    logic              w_done;

    // A count of 1 means the result is on the forwarding path this cycle,
    // so the register is already readable.
    for (genvar gi = 0; gi < 64; gi++) begin : g_pend
        if (gi == 0) begin : g_zero
            assign w_pending[gi] = 1'b0;
        end else begin : g_live
            assign w_pending[gi] = r_lf[gi] | (r_cnt[gi] > c_ONE);
        end
    end

    // Hazard detection and issue decision from decode fields and current state
    always_comb begin
        w_dst           = {(dec.id_rw == 2'b10), dec.id_rd};
        w_has_write     = ((dec.id_rw == 2'b01) && (dec.id_rd != 5'd0)) ||
                          (dec.id_rw == 2'b10);
        w_is_long       = (dec.id_wait == LONG_CODE);
        w_raw_s         = dec.id_use_s & w_pending[dec.id_rs];
        w_raw_t         = dec.id_use_t & w_pending[dec.id_rt];
        w_waw           = w_has_write & w_pending[w_dst];
        // long_busy is the pre-clear value, so a long op presented in the
        // long_done cycle still waits one cycle.
        w_long_conflict = w_is_long & r_long_busy;
        w_stall         = dec.id_valid &
                          (w_raw_s | w_raw_t | w_waw | w_long_conflict);
        w_issue         = dec.id_valid & ~w_stall & ~dec.flush;
        w_set           = w_issue & w_has_write;
        w_done          = long_done & r_long_busy;
    end

    assign dec.stall = w_stall;
    assign dec.issue = w_issue;
    assign long_busy = r_long_busy;
    assign busy_gpr  = w_pending[31:0];
    assign busy_fpr  = w_pending[63:32];

    // Per-register countdown and long-flag update; an issued write overrides
    // both the decrement and the long_done clear for its own destination.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < 64; i++) begin
                r_cnt[i] <= c_ZERO;
            end
            r_lf <= '0;
        end else begin
            for (int i = 1; i < 64; i++) begin
                if (w_set && (w_dst == 6'(i))) begin
                    if (w_is_long) begin
                        r_lf[i]  <= 1'b1;
                        r_cnt[i] <= c_ZERO;
                    end else begin
                        r_lf[i]  <= 1'b0;
                        r_cnt[i] <= dec.id_wait;
                    end
                end else begin
                    if (!r_lf[i] && (r_cnt[i] != c_ZERO)) begin
                        r_cnt[i] <= r_cnt[i] - c_ONE;
                    end
                    if (w_done && r_long_wr && (r_long_dst == 6'(i))) begin
                        r_lf[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Long-latency unit occupancy and the destination it will release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_long_busy <= 1'b0;
            r_long_dst  <= 6'd0;
            r_long_wr   <= 1'b0;
        end else if (w_issue && w_is_long) begin
            r_long_busy <= 1'b1;
            r_long_wr   <= w_has_write;
            if (w_has_write) begin
                r_long_dst <= w_dst;
            end
        end else if (w_done) begin
            r_long_busy <= 1'b0;
            r_long_wr   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scoreboard
// Description : Directed self-checking bench for issue_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

    localparam logic [4:0] c_LONG = 5'b11111;

    logic clk;
    logic rstn;
    logic long_done;
    logic long_busy;
    logic [31:0] busy_gpr;
    logic [31:0] busy_fpr;

    int n_cmp;
    int n_err;

    issue_scoreboard_if #(.WAIT_W(5)) dif ();

    issue_scoreboard #(.WAIT_W(5), .LONG_CODE(c_LONG)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .dec       (dif),
        .long_done (long_done),
        .long_busy (long_busy),
        .busy_gpr  (busy_gpr),
        .busy_fpr  (busy_fpr)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] rs, input logic us,
                         input logic [5:0] rt, input logic ut, input logic [1:0] rw,
                         input logic [4:0] rd, input logic [4:0] w, input logic fl);
        dif.id_valid = v;
        dif.id_rs    = rs;
        dif.id_use_s = us;
        dif.id_rt    = rt;
        dif.id_use_t = ut;
        dif.id_rw    = rw;
        dif.id_rd    = rd;
        dif.id_wait  = w;
        dif.flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b0;
        long_done = 1'b0;
        idle();

        // ---- reset state ----
        #2;
        chk("rst_busy_gpr", {32'd0, busy_gpr}, 64'd0);
        chk("rst_busy_fpr", {32'd0, busy_fpr}, 64'd0);
        chk("rst_long_busy", {63'd0, long_busy}, 64'd0);
        chk("rst_stall", {63'd0, dif.stall}, 64'd0);
        #11 rstn = 1'b1;
        tick();

        // ---- GPR load-use: write GPR5 W=4, consumer stalls 3 cycles ----
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd5, 5'd4, 1'b0);
        #4;
        chk("lu_prod_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        drive(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("lu_stall", {63'd0, dif.stall}, 64'd1);
            chk("lu_busy5", {63'd0, busy_gpr[5]}, 64'd1);
            tick();
        end
        #4;
        chk("lu_cons_issue", {63'd0, dif.issue}, 64'd1);
        chk("lu_busy5_fall", {63'd0, busy_gpr[5]}, 64'd0);
        tick();

        // ---- FPR separation: write FPR3 W=6 ----
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b10, 5'd3, 5'd6, 1'b0);
        #4;
        chk("fs_prod_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        drive(1'b1, 6'h03, 1'b1, 6'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        #1;
        chk("fs_gpr3_nostall", {63'd0, dif.stall}, 64'd0);
        chk("fs_busy_gpr", {32'd0, busy_gpr}, 64'd0);
        chk("fs_busy_fpr", {32'd0, busy_fpr}, 64'h8);
        drive(1'b1, 6'h23, 1'b1, 6'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("fs_fpr3_stall", {63'd0, dif.stall}, 64'd1);
            tick();
        end
        #3;
        chk("fs_fpr3_issue", {63'd0, dif.issue}, 64'd1);
        tick();

        // ---- Long unit: div to GPR8, then inv to FPR1 ----
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd8, c_LONG, 1'b0);
        #4;
        chk("lg_div_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b10, 5'd1, c_LONG, 1'b0);
        #4;
        chk("lg_busy", {63'd0, long_busy}, 64'd1);
        chk("lg_busy_gpr", {32'd0, busy_gpr}, 64'h100);
        for (int k = 0; k < 3; k++) begin
            chk("lg_inv_stall", {63'd0, dif.stall}, 64'd1);
            tick();
            #4;
        end
        long_done = 1'b1;
        #1;
        chk("lg_done_cycle_stall", {63'd0, dif.stall}, 64'd1);
        drive(1'b1, 6'd8, 1'b1, 6'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        #1;
        chk("lg_done_cycle_cons", {63'd0, dif.stall}, 64'd1);
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b10, 5'd1, c_LONG, 1'b0);
        tick();
        long_done = 1'b0;
        drive(1'b1, 6'd8, 1'b1, 6'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        #3;
        chk("lg_busy_fall", {63'd0, long_busy}, 64'd0);
        chk("lg_cons_go", {63'd0, dif.issue}, 64'd1);
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b10, 5'd1, c_LONG, 1'b0);
        #1;
        chk("lg_inv_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        idle();
        #4;
        chk("lg_inv_busy", {63'd0, long_busy}, 64'd1);
        chk("lg_inv_fpr1", {32'd0, busy_fpr}, 64'h2);
        long_done = 1'b1;
        tick();
        long_done = 1'b0;
        #4;
        chk("lg_inv_done", {63'd0, long_busy}, 64'd0);
        chk("lg_inv_fpr1_clr", {32'd0, busy_fpr}, 64'd0);
        // long_done while idle must be ignored
        long_done = 1'b1;
        tick();
        long_done = 1'b0;
        #4;
        chk("lg_spurious_done", {63'd0, long_busy}, 64'd0);
        tick();

        // ---- WAW: GPR4 W=5 then GPR4 W=1 ----
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd4, 5'd5, 1'b0);
        #4;
        chk("waw_first_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd4, 5'd1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("waw_stall", {63'd0, dif.stall}, 64'd1);
            tick();
        end
        #4;
        chk("waw_second_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        idle();
        #4;
        chk("waw_busy4_clear", {32'd0, busy_gpr}, 64'd0);
        tick();

        // ---- GPR0 writes never tracked ----
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd0, 5'd7, 1'b0);
        #4;
        chk("g0_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd0, c_LONG, 1'b0);
        #4;
        chk("g0_busy0", {63'd0, busy_gpr[0]}, 64'd0);
        chk("g0_long_issue", {63'd0, dif.issue}, 64'd1);
        tick();
        drive(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 2'b01, 5'd0, 5'd3, 1'b0);
        #4;
        chk("g0_cons_nostall", {63'd0, dif.stall}, 64'd0);
        chk("g0_busy_all", {32'd0, busy_gpr}, 64'd0);
        chk("g0_longbusy", {63'd0, long_busy}, 64'd1);
        idle();
        long_done = 1'b1;
        tick();
        long_done = 1'b0;
        #4;
        chk("g0_long_clear", {63'd0, long_busy}, 64'd0);
        tick();

        // ---- Flush blocks issue ----
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd9, 5'd3, 1'b1);
        #4;
        chk("fl_issue", {63'd0, dif.issue}, 64'd0);
        chk("fl_stall", {63'd0, dif.stall}, 64'd0);
        tick();
        idle();
        #4;
        chk("fl_busy9", {63'd0, busy_gpr[9]}, 64'd0);
        tick();

        // ---- Reset mid-operation ----
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd10, 5'd8, 1'b0);
        tick();
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd11, 5'd8, 1'b0);
        tick();
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b10, 5'd2, 5'd8, 1'b0);
        tick();
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 2'b01, 5'd12, c_LONG, 1'b0);
        tick();
        idle();
        #2;
        chk("pre_rst_gpr", {32'd0, busy_gpr}, 64'h1C00);
        chk("pre_rst_fpr", {32'd0, busy_fpr}, 64'h4);
        chk("pre_rst_long", {63'd0, long_busy}, 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_gpr", {32'd0, busy_gpr}, 64'd0);
        chk("mid_rst_fpr", {32'd0, busy_fpr}, 64'd0);
        chk("mid_rst_long", {63'd0, long_busy}, 64'd0);
        #10 rstn = 1'b1;
        tick();
        #4;
        chk("post_rst_gpr", {32'd0, busy_gpr}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register scoreboard and issue controller that sits between `decode` and the execute stage. It tracks every in-flight register write, covering the 32 GPRs and 32 FPRs, with a per-register countdown seeded from decode's `wait_time`. It holds the decoded instruction (`stall`) on RAW hazards, WAW hazards and contention for the single unpipelined long-latency unit (div/inv/sqrt). It frees operands exactly when the forwarding path can supply them.

## Interface
Parameters:
- `WAIT_W`, default 5: width of the wait-time field and of each countdown.
- `LONG_CODE`, default 5'b11111: wait-time code meaning variable latency, completed by `long_done`.

Ports:
- `clk`  in  1: single clock; all state updates on posedge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `id_valid`  in  1: decode holds a valid instruction.
- `id_rs`  in  6: source s; bit 5 = FPR, [4:0] = index.
- `id_rt`  in  6: source t, same encoding.
- `id_use_s`, `id_use_t`  in  1 each: the corresponding source is read.
- `id_rw`  in  2: 00 no write, 01 GPR write, 10 FPR write, 11 treated as 00.
- `id_rd`  in  5: destination index.
- `id_wait`  in  WAIT_W: cycles until the result is forwardable, or `LONG_CODE`.
- `flush`  in  1: suppresses issue this cycle (branch redirect).
- `long_done`  in  1: one-cycle pulse when the long unit writes back.
- `stall`  out  1: decode must hold its instruction.
- `issue`  out  1: instruction accepted this cycle.
- `long_busy`  out  1: long unit occupied.
- `busy_gpr`  out  32: per-GPR pending flag.
- `busy_fpr`  out  32: per-FPR pending flag.

## Operation
- State:
  - 64 countdowns `cnt[i]` (WAIT_W bits); i = {file, index}, file 1 = FPR.
  - 64 long flags `lf[i]`.
  - `long_busy` and `long_dst` (6 bits).
- Register `pending(i)` = `lf[i]` | (`cnt[i]` > 1). A count of 1 is not pending, because the value is forwarded that cycle.
- GPR 0 is never pending; writes to GPR 0 are not tracked.
- `dst` = {`id_rw`==10, `id_rd`}. A write exists when `id_rw` is 01 or 10 and the target is not GPR 0.
- `stall` = `id_valid` & (any of the following):
  - `id_use_s` & pending(`id_rs`);
  - `id_use_t` & pending(`id_rt`);
  - write & pending(`dst`) (WAW);
  - `id_wait`==`LONG_CODE` & `long_busy`.
- `issue` = `id_valid` & ~`stall` & ~`flush`.
- Per-cycle update, every i not targeted by an issue: if ~`lf[i]` & `cnt[i]` != 0, then `cnt[i]` decrements by 1. It saturates at 0 and never wraps.
- On `issue` with a write:
  - If `id_wait` != `LONG_CODE`: `cnt[dst]` <= `id_wait` and `lf[dst]` <= 0. Set takes priority over the decrement.
  - If `id_wait` == `LONG_CODE`: `lf[dst]` <= 1, `cnt[dst]` <= 0, `long_dst` <= dst.
- On `issue` with `id_wait`==`LONG_CODE`, with or without a write: `long_busy` <= 1.
- `long_done`: `long_busy` <= 0 and `lf[long_dst]` <= 0.
- `long_done` is ignored while `long_busy` is 0.
- `long_busy` is sampled before the `long_done` clear. A long instruction presented in the `long_done` cycle therefore stalls one cycle.
- Re-issue to a register whose `cnt` is 1 is legal: the counter reloads.
- `busy_gpr[k]` = pending({0,k}); `busy_fpr[k]` = pending({1,k}).

## Timing
- `stall` and `issue` are combinational from the inputs and the current state, with zero latency.
- The scoreboard state updates on the posedge where `issue`=1.
- A consumer of a result with `id_wait`=W, issued back-to-back, stalls W-1 cycles, then issues in the cycle the count reads 1.
- W=1 and W=0 never stall a consumer.
- A long-latency consumer issues in the cycle after the `long_done` pulse.
- Reset (asynchronous assert, synchronous-safe release) gives:
  - all `cnt`=0, all `lf`=0;
  - `long_busy`=0, `long_dst`=0;
  - `busy_gpr`=`busy_fpr`=0;
  - `stall`=0 when `id_valid`=0.
- Reset mid-operation discards all pending entries. Writes from the execute stage that are still in flight are not tracked.
- `flush` never clears pending entries; it only blocks the current issue.
- `flush` together with `stall`: `issue`=0, and the state is unchanged apart from the decrement.

## Test plan
- GPR load-use: issue write GPR 5 with `id_wait`=4, then a consumer of `id_rs`=5 → `stall`=1 for 3 cycles, `issue` in cycle 4; `busy_gpr[5]` falls in that same cycle.
- FPR separation: write FPR 3 with `id_wait`=6, then a consumer of GPR 3 → no stall. A consumer of FPR 3 (`id_rs`=6'h23) → 5 stall cycles.
- Long unit: issue div to GPR 8 (`LONG_CODE`), then an inv to FPR 1 → stall until `long_done`, plus one extra cycle. A GPR 8 consumer issues in the cycle after `long_done`; `long_busy` is 1→0 on that pulse.
- WAW and GPR 0:
  - write GPR 4 with `id_wait`=5, then write GPR 4 with `id_wait`=1 → stalls until `cnt[4]`=1;
  - writes to GPR 0 with any wait → `busy_gpr[0]` is always 0 and never causes a stall.
- Flush and reset:
  - `flush` with a valid write to GPR 9 → `issue`=0 and `busy_gpr[9]` stays 0;
  - assert `rstn`=0 while the long unit is busy and 3 counters are live → all busy outputs read 0 immediately, and `long_busy`=0.
